laser_job_ctrl: RTL and testbench
=================================

# laser_job_ctrl

Job sequencer in front of the two-circle LASER search engine. It accepts point sets from a host over a valid/ready stream into a one-job buffer, parks the engine in reset while idle, kicks it and replays the buffered points at one point per cycle. It then waits for the engine's done pulse and returns the two circle centres to the host over a second valid/ready stream. An optional watchdog covers hung searches. Buffer filling overlaps the engine search, so the next job loads while the current one runs.

## Interface
Parameters:
- NPTS, 40, points per job; engine samples exactly this many.
- TO_W, 16, watchdog counter width; timeout after 2^TO_W-1 WAIT cycles.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high; clock CLK.
- IN_VALID  in  1  host point beat valid.
- IN_READY  out  1  controller accepts a beat; equals !buf_full.
- IN_X, IN_Y  in  4 each  point coordinates.
- ENG_RST  out  1  engine reset.
- ENG_X, ENG_Y  out  4 each  point to engine.
- ENG_DONE  in  1  engine done pulse, 1 cycle.
- ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y  in  4 each  engine result, valid while ENG_DONE=1.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  host accepts result.
- OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y  out  4 each  captured centres.
- OUT_ERR  out  1  result produced by watchdog timeout.

## Operation
- Buffer: NPTS x 8-bit array with wr_ptr (6 bit) and buf_full flag.
  - A beat is accepted when IN_VALID && IN_READY and is written at wr_ptr.
  - The beat with wr_ptr==NPTS-1 wraps wr_ptr to 0 and sets buf_full.
  - Filling is independent of the FSM state.
- Engine FSM, with states IDLE, KICK, FEED, WAIT, RESULT:
  - IDLE: ENG_RST=1. Go to KICK when buf_full=1.
  - KICK: ENG_RST=1 for exactly one cycle, rd_ptr=0. Go to FEED.
  - FEED: ENG_RST=0, ENG_X/ENG_Y=buf[rd_ptr], rd_ptr increments every cycle.
    - The cycle with rd_ptr==NPTS-1 clears buf_full at its end and moves to WAIT.
  - WAIT: ENG_RST=0, ENG_X/ENG_Y=0.
    - On ENG_DONE, capture the four ENG_C* values into the OUT_C* registers, set OUT_ERR=0 and go to RESULT.
  - RESULT: ENG_RST=1, OUT_VALID=1. On OUT_READY go to IDLE.
- ENG_DONE outside WAIT is ignored.
- ENG_X/ENG_Y are 0 in every state except FEED.
- OUT_C* hold their last captured value until the next capture.

## Timing
- Reset values: IN_READY=1 (buf_full=0), ENG_RST=1, ENG_X/ENG_Y=0, OUT_VALID=0, OUT_C*=0, OUT_ERR=0. The FSM resets to IDLE and wr_ptr, rd_ptr and the watchdog counter reset to 0.
- RST asserted mid-job discards the buffered points and any pending result. The engine stays in reset because ENG_RST=1.
- IN_READY is registered. After the last beat is accepted at cycle t:
  - IN_READY=0 from t+1.
  - IDLE->KICK at t+1, KICK at t+2.
  - FEED cycles t+3 .. t+2+NPTS.
  - The engine sees point k in FEED cycle k; ENG_RST falls exactly at the first FEED cycle.
- IN_READY returns to 1 the cycle after the last FEED cycle. The host may load the next job during WAIT and RESULT.
- ENG_DONE at cycle d in WAIT gives OUT_VALID=1 from d+1.
- OUT_VALID holds until a cycle with OUT_READY=1. OUT_VALID=0 the next cycle.
- IDLE->KICK occurs no earlier than the cycle after the RESULT handshake.
- OUT_READY while OUT_VALID=0 has no effect.

## Configuration
- LASER_CTRL_WDOG_EN defined:
  - A TO_W-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching 2^TO_W-1 without ENG_DONE, go to RESULT with OUT_ERR=1 and OUT_C*=0.
  - If ENG_DONE and the terminal count occur in the same cycle, ENG_DONE wins (OUT_ERR=0).
- LASER_CTRL_WDOG_EN undefined:
  - No counter. WAIT exits only on ENG_DONE.
  - OUT_ERR is constant 0.

## Test plan
- Reset, then 40 beats with point k=(k%16, k/16), IN_VALID continuous -> IN_READY=1 for 40 accepts then 0. ENG_RST=1 through KICK. ENG_X/ENG_Y sequence matches the buffer order exactly over 40 FEED cycles.
- Engine model pulses ENG_DONE 500 cycles into WAIT with (3,4,11,9), OUT_READY=1 -> OUT_VALID 1 cycle later with OUT_C1X=3, OUT_C1Y=4, OUT_C2X=11, OUT_C2Y=9, OUT_ERR=0.
- Load job B during WAIT of job A and hold OUT_READY=0 for 20 cycles -> OUT_VALID held 20 cycles with stable data. KICK for B only after the handshake. B's points are fed unchanged.
- IN_VALID toggled randomly plus ENG_DONE injected in IDLE/FEED -> no spurious result. Point order preserved.
- RST asserted at FEED cycle 17 -> next cycle IN_READY=1, ENG_RST=1, OUT_VALID=0. A fresh job then completes normally.
- With LASER_CTRL_WDOG_EN and TO_W=4, no ENG_DONE -> OUT_VALID after 15 WAIT cycles with OUT_ERR=1 and OUT_C*=0. ENG_DONE on cycle 15 -> OUT_ERR=0.

Source files
------------

// File: rtl/laser_job_ctrl_if.sv
// Host-side streams of laser_job_ctrl: point beats in, circle-centre results out.
interface laser_job_ctrl_if;
  logic       IN_VALID;
  logic       IN_READY;
  logic [3:0] IN_X;
  logic [3:0] IN_Y;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [3:0] OUT_C1X;
  logic [3:0] OUT_C1Y;
  logic [3:0] OUT_C2X;
  logic [3:0] OUT_C2Y;
  logic       OUT_ERR;

  modport master (
    output IN_VALID, IN_X, IN_Y, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y, OUT_ERR
  );

  modport slave (
    input  IN_VALID, IN_X, IN_Y, OUT_READY,
    output IN_READY, OUT_VALID, OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y, OUT_ERR
  );
endinterface

// File: rtl/laser_job_ctrl.sv
// Job sequencer for the LASER two-circle engine: one-job point buffer, engine kick/feed, result handshake.
// Defining LASER_CTRL_WDOG_EN adds a watchdog that ends a hung search with OUT_ERR=1.
//
// state  | meaning
// IDLE   | engine held in reset, waiting for a full buffer
// KICK   | single reset cycle before feeding, rd_ptr cleared
// FEED   | one buffered point per cycle to the engine
// WAIT   | engine searching, waiting for ENG_DONE (or watchdog)
// RESULT | centres offered to host, engine back in reset
module laser_job_ctrl #(
  parameter int NPTS = 40,
  parameter int TO_W = 16
) (
  input  logic            CLK,
  input  logic            RST,
  laser_job_ctrl_if.slave host,
  output logic            ENG_RST,
  output logic [3:0]      ENG_X,
  output logic [3:0]      ENG_Y,
  input  logic            ENG_DONE,
  input  logic [3:0]      ENG_C1X,
  input  logic [3:0]      ENG_C1Y,
  input  logic [3:0]      ENG_C2X,
  input  logic [3:0]      ENG_C2Y
);
  typedef enum logic [2:0] {IDLE, KICK, FEED, WAIT, RESULT} state_t;

  localparam logic [5:0] LAST = 6'(NPTS - 1);

  state_t     state, state_nxt;
  logic [7:0] buf_mem [NPTS];
  logic [5:0] wr_ptr;
  logic [5:0] rd_ptr;
  logic       buf_full;
  logic       accept;
  logic       wd_tc;

  assign accept        = host.IN_VALID && !buf_full;
  assign host.IN_READY = !buf_full;

  always_ff @(posedge CLK) begin
    if (accept) buf_mem[wr_ptr] <= {host.IN_X, host.IN_Y};
  end

  // Filling runs independently of the FSM so the next job loads during WAIT/RESULT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      buf_full <= 1'b0;
    end else begin
      if (accept) begin
        if (wr_ptr == LAST) begin
          wr_ptr   <= '0;
          buf_full <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 6'd1;
        end
      end
      if (state == FEED && rd_ptr == LAST) buf_full <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == KICK)      rd_ptr <= '0;
      else if (state == FEED) rd_ptr <= rd_ptr + 6'd1;
    end
  end

  always_comb begin
    state_nxt      = state;
    ENG_RST        = 1'b1;
    ENG_X          = 4'd0;
    ENG_Y          = 4'd0;
    host.OUT_VALID = 1'b0;
    case (state)
      IDLE:   if (buf_full) state_nxt = KICK;
      KICK:   state_nxt = FEED;
      FEED: begin
        ENG_RST        = 1'b0;
        {ENG_X, ENG_Y} = buf_mem[rd_ptr];
        if (rd_ptr == LAST) state_nxt = WAIT;
      end
      WAIT: begin
        ENG_RST = 1'b0;
        if (ENG_DONE || wd_tc) state_nxt = RESULT;
      end
      RESULT: begin
        host.OUT_VALID = 1'b1;
        if (host.OUT_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ENG_DONE has priority over a simultaneous watchdog terminal count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      host.OUT_C1X <= '0;
      host.OUT_C1Y <= '0;
      host.OUT_C2X <= '0;
      host.OUT_C2Y <= '0;
    end else if (state == WAIT && ENG_DONE) begin
      host.OUT_C1X <= ENG_C1X;
      host.OUT_C1Y <= ENG_C1Y;
      host.OUT_C2X <= ENG_C2X;
      host.OUT_C2Y <= ENG_C2Y;
    end else if (wd_tc) begin
      host.OUT_C1X <= '0;
      host.OUT_C1Y <= '0;
      host.OUT_C2X <= '0;
      host.OUT_C2Y <= '0;
    end
  end

`ifdef LASER_CTRL_WDOG_EN
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  logic [TO_W-1:0] wd_cnt;

  // Counter holds the number of completed WAIT cycles; the cycle that would reach all-ones times out.
  always_ff @(posedge CLK) begin
    if (RST || state != WAIT) wd_cnt <= '0;
    else                      wd_cnt <= wd_cnt + TO_W'(1);
  end

  assign wd_tc = (state == WAIT) && (wd_cnt == WD_LAST);

  always_ff @(posedge CLK) begin
    if (RST)                          host.OUT_ERR <= 1'b0;
    else if (state == WAIT && ENG_DONE) host.OUT_ERR <= 1'b0;
    else if (wd_tc)                   host.OUT_ERR <= 1'b1;
  end
`else
  assign wd_tc = 1'b0;
  // TO_W only sizes the watchdog; this constant-0 form keeps the parameter referenced.
  assign host.OUT_ERR = (TO_W < 1);
`endif
endmodule

// File: tb/tb_laser_job_ctrl.sv
// Self-checking bench for laser_job_ctrl: job-level model compared every cycle plus literal spot checks.
module tb_laser_job_ctrl;
  localparam int NPTS = 40;
`ifdef LASER_CTRL_WDOG_EN
  localparam int TO_W = 4;
  localparam int DONE_DLY = 10;
  localparam bit WDOG = 1'b1;
`else
  localparam int TO_W = 16;
  localparam int DONE_DLY = 500;
  localparam bit WDOG = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  laser_job_ctrl_if hif();
  logic       ENG_RST, ENG_DONE;
  logic [3:0] ENG_X, ENG_Y, ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y;

  laser_job_ctrl #(.NPTS(NPTS), .TO_W(TO_W)) dut (
    .CLK(CLK), .RST(RST), .host(hif),
    .ENG_RST(ENG_RST), .ENG_X(ENG_X), .ENG_Y(ENG_Y), .ENG_DONE(ENG_DONE),
    .ENG_C1X(ENG_C1X), .ENG_C1Y(ENG_C1Y), .ENG_C2X(ENG_C2X), .ENG_C2Y(ENG_C2Y)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Job-level model: a buffer, a job timeline position and a pending result.
  bit         m_full, m_busy, m_res, m_err;
  int         m_wr, m_t, m_wait;
  logic [7:0] m_buf [NPTS];
  logic [3:0] m_c [4];

  function automatic bit in_wait();
    return m_busy && !m_res && (m_t > NPTS);
  endfunction

  always @(posedge CLK) begin : model
    bit f0;
    cyc++;
    if (RST) begin
      m_full = 0; m_busy = 0; m_res = 0; m_err = 0;
      m_wr = 0; m_t = 0; m_wait = 0;
      for (int i = 0; i < 4; i++) m_c[i] = 4'd0;
    end else begin
      f0 = m_full;
      if (hif.IN_VALID && !f0) begin
        m_buf[m_wr] = {hif.IN_X, hif.IN_Y};
        if (m_wr == NPTS - 1) begin m_wr = 0; m_full = 1; end
        else m_wr++;
      end
      if (!m_busy) begin
        if (f0) begin m_busy = 1; m_t = 0; end
      end else if (m_res) begin
        if (hif.OUT_READY) begin m_res = 0; m_busy = 0; end
      end else if (m_t <= NPTS) begin
        if (m_t == NPTS) begin m_full = 0; m_wait = 0; end
        m_t++;
      end else if (ENG_DONE) begin
        m_c[0] = ENG_C1X; m_c[1] = ENG_C1Y; m_c[2] = ENG_C2X; m_c[3] = ENG_C2Y;
        m_err = 0; m_res = 1;
      end else begin
        m_wait++;
        if (WDOG && m_wait == (2 ** TO_W) - 1) begin
          for (int i = 0; i < 4; i++) m_c[i] = 4'd0;
          m_err = 1; m_res = 1;
        end
      end
    end
  end

  always @(negedge CLK) begin : compare
    bit feeding;
    logic [7:0] ep;
    if (chk_en) begin
      feeding = m_busy && !m_res && m_t >= 1 && m_t <= NPTS;
      ep = feeding ? m_buf[m_t - 1] : 8'd0;
      chk("in_ready",  32'(hif.IN_READY), 32'(!m_full));
      chk("eng_rst",   32'(ENG_RST), 32'(!(m_busy && !m_res && m_t >= 1)));
      chk("eng_x",     32'(ENG_X), 32'(ep[7:4]));
      chk("eng_y",     32'(ENG_Y), 32'(ep[3:0]));
      chk("out_valid", 32'(hif.OUT_VALID), 32'(m_res));
      chk("out_c1x",   32'(hif.OUT_C1X), 32'(m_c[0]));
      chk("out_c1y",   32'(hif.OUT_C1Y), 32'(m_c[1]));
      chk("out_c2x",   32'(hif.OUT_C2X), 32'(m_c[2]));
      chk("out_c2y",   32'(hif.OUT_C2Y), 32'(m_c[3]));
      chk("out_err",   32'(hif.OUT_ERR), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] pt(input int kind, input int k);
    int x, y;
    case (kind)
      0:       begin x = k % 16;        y = k / 16;       end
      1:       begin x = 15 - (k % 16); y = (k * 7) % 16; end
      2:       begin x = (k * 3) % 16;  y = (k + 5) % 16; end
      3:       begin x = (k * 5) % 16;  y = 15 - (k % 16); end
      default: begin x = (k + kind) % 16; y = (k * 11) % 16; end
    endcase
    return {x[3:0], y[3:0]};
  endfunction

  task automatic load_job(input int kind, input bit rnd, output int t_last);
    int k = 0, g = 0;
    bit v, acc;
    logic [7:0] p;
    t_last = 0;
    while (k < NPTS && g < 3000) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      p = pt(kind, k);
      hif.IN_VALID = v; hif.IN_X = p[7:4]; hif.IN_Y = p[3:0];
      acc = v && !m_full;
      if (acc) t_last = cyc;
      tick();
      if (acc) k++;
      g++;
    end
    hif.IN_VALID = 1'b0;
    if (k < NPTS) chk("load_timeout_beats", k, NPTS);
  endtask

  task automatic wait_wcyc(input int n);
    int g = 0;
    while (!(in_wait() && m_wait + 1 == n) && g < 5000) begin tick(); g++; end
    if (g >= 5000) chk("wait_cycle_timeout", g, 0);
  endtask

  task automatic pulse_done(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    ENG_DONE = 1'b1; ENG_C1X = a; ENG_C1Y = b; ENG_C2X = c; ENG_C2Y = d;
    tick();
    ENG_DONE = 1'b0; ENG_C1X = 4'd0; ENG_C1Y = 4'd0; ENG_C2X = 4'd0; ENG_C2Y = 4'd0;
  endtask

  initial begin : guard
    #800000;
    $display("FAIL global_timeout actual=%0d required=<80000 cycles", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    int t_a, t_b, t_c, t_x, fall, g, w0;
    hif.IN_VALID = 0; hif.IN_X = 0; hif.IN_Y = 0; hif.OUT_READY = 1;
    ENG_DONE = 0; ENG_C1X = 0; ENG_C1Y = 0; ENG_C2X = 0; ENG_C2Y = 0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_in_ready", 32'(hif.IN_READY), 1);
    chk("rst_eng_rst", 32'(ENG_RST), 1);
    chk("rst_eng_x", 32'(ENG_X), 0);
    chk("rst_out_valid", 32'(hif.OUT_VALID), 0);
    chk("rst_out_c2y", 32'(hif.OUT_C2Y), 0);
    chk("rst_out_err", 32'(hif.OUT_ERR), 0);
    tick();

    // Job A: continuous beats, kick/feed latency pinned by literals.
    load_job(0, 1'b0, t_a);
    @(negedge CLK);
    chk("ready_low_after_last", 32'(hif.IN_READY), 0);
    g = 0;
    while (ENG_RST !== 1'b0 && g < 20) begin tick(); @(negedge CLK); g++; end
    fall = cyc;
    chk("eng_rst_fall_latency", fall - t_a, 3);
    chk("feed0_x", 32'(ENG_X), 0);
    chk("feed0_y", 32'(ENG_Y), 0);
    repeat (17) tick();
    @(negedge CLK);
    chk("feed17_x", 32'(ENG_X), 1);
    chk("feed17_y", 32'(ENG_Y), 1);
    wait_wcyc(1);
    fork
      load_job(1, 1'b0, t_b);
      begin
        wait_wcyc(DONE_DLY);
        pulse_done(4'd3, 4'd4, 4'd11, 4'd9);
        @(negedge CLK);
        chk("a_valid", 32'(hif.OUT_VALID), 1);
        chk("a_c1x", 32'(hif.OUT_C1X), 3);
        chk("a_c1y", 32'(hif.OUT_C1Y), 4);
        chk("a_c2x", 32'(hif.OUT_C2X), 11);
        chk("a_c2y", 32'(hif.OUT_C2Y), 9);
        chk("a_err", 32'(hif.OUT_ERR), 0);
        tick();
      end
    join

    // Job B: result held 20 cycles, job C loads meanwhile with ragged IN_VALID.
    wait_wcyc(1);
    fork
      load_job(2, 1'b1, t_c);
      begin
        wait_wcyc(DONE_DLY);
        hif.OUT_READY = 1'b0;
        pulse_done(4'd7, 4'd1, 4'd2, 4'd14);
        for (int i = 0; i < 20; i++) begin
          @(negedge CLK);
          chk("b_hold_valid", 32'(hif.OUT_VALID), 1);
          chk("b_hold_c1x", 32'(hif.OUT_C1X), 7);
          chk("b_hold_c2y", 32'(hif.OUT_C2Y), 14);
          chk("b_hold_eng_rst", 32'(ENG_RST), 1);
          tick();
          ENG_DONE = (i == 4);
          ENG_C1X = (i == 4) ? 4'd9 : 4'd0;
          ENG_C2Y = (i == 4) ? 4'd9 : 4'd0;
        end
        ENG_DONE = 1'b0; ENG_C1X = 4'd0; ENG_C2Y = 4'd0;
        hif.OUT_READY = 1'b1;
        tick();
        @(negedge CLK);
        chk("b_valid_drop", 32'(hif.OUT_VALID), 0);
        tick();
      end
    join

    // Job C: spurious ENG_DONE pulses through IDLE/KICK/FEED must be ignored.
    g = 0;
    while (!(m_busy && !m_res && m_t == 10) && g < 300) begin
      ENG_DONE = (g % 3 == 0);
      ENG_C1X = 4'd15; ENG_C1Y = 4'd15; ENG_C2X = 4'd15; ENG_C2Y = 4'd15;
      tick();
      g++;
    end
    ENG_DONE = 0; ENG_C1X = 0; ENG_C1Y = 0; ENG_C2X = 0; ENG_C2Y = 0;
    @(negedge CLK);
    chk("c_no_spurious_valid", 32'(hif.OUT_VALID), 0);
    chk("c_c1x_kept", 32'(hif.OUT_C1X), 7);
    wait_wcyc(DONE_DLY);
    pulse_done(4'd5, 4'd6, 4'd7, 4'd8);
    @(negedge CLK);
    chk("c_c1x", 32'(hif.OUT_C1X), 5);
    chk("c_c2y", 32'(hif.OUT_C2Y), 8);
    tick();

    // Job D: reset during FEED cycle 17, then job E completes normally.
    load_job(3, 1'b0, t_x);
    g = 0;
    while (!(m_busy && !m_res && m_t == 18) && g < 200) begin tick(); g++; end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("d_rst_in_ready", 32'(hif.IN_READY), 1);
    chk("d_rst_eng_rst", 32'(ENG_RST), 1);
    chk("d_rst_out_valid", 32'(hif.OUT_VALID), 0);
    chk("d_rst_out_c1x", 32'(hif.OUT_C1X), 0);
    tick();
    load_job(4, 1'b0, t_x);
    wait_wcyc(DONE_DLY);
    pulse_done(4'd12, 4'd0, 4'd1, 4'd15);
    @(negedge CLK);
    chk("e_valid", 32'(hif.OUT_VALID), 1);
    chk("e_c1x", 32'(hif.OUT_C1X), 12);
    chk("e_c2y", 32'(hif.OUT_C2Y), 15);
    tick();

`ifdef LASER_CTRL_WDOG_EN
    // Job F: no ENG_DONE, watchdog ends the search after 15 WAIT cycles.
    load_job(5, 1'b0, t_x);
    wait_wcyc(1);
    w0 = cyc;
    @(negedge CLK);
    g = 0;
    while (hif.OUT_VALID !== 1'b1 && g < 100) begin tick(); @(negedge CLK); g++; end
    chk("wdog_latency", cyc - w0, 15);
    chk("wdog_err", 32'(hif.OUT_ERR), 1);
    chk("wdog_c1x", 32'(hif.OUT_C1X), 0);
    chk("wdog_c2y", 32'(hif.OUT_C2Y), 0);
    tick();
    // Job G: ENG_DONE on the terminal WAIT cycle wins.
    load_job(6, 1'b0, t_x);
    wait_wcyc(15);
    pulse_done(4'd2, 4'd3, 4'd4, 4'd5);
    @(negedge CLK);
    chk("g_valid", 32'(hif.OUT_VALID), 1);
    chk("g_err", 32'(hif.OUT_ERR), 0);
    chk("g_c1x", 32'(hif.OUT_C1X), 2);
    tick();
`else
    w0 = 0;
`endif

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
